// File: rtl/gb_noise_channel_gen.sv
// gb_noise_channel_gen: Game Boy style noise channel.
// An LFSR noise source is clocked by a programmable frequency timer. Its output
// bit gates the envelope volume onto `level`. A length counter and the DAC-enable
// condition both control whether the channel is active.
// Optional build macro GB_NOISE_LFSR_OBS_EN adds the observation outputs
// `lfsr_state` (registered LFSR value) and `lfsr_shift` (one-cycle pulse per shift).
// With the macro undefined, neither port nor its logic exists.
module gb_noise_channel_gen #(
  parameter int LFSR_W    = 15,
  parameter int SHORT_TAP = 6,
  parameter int LEN_W     = 6,
  parameter int VOL_W     = 4,
  parameter int TIMER_W   = 22
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_length_ctr,
  input  logic               clk_vol_env,
  input  logic [LEN_W-1:0]   length,
  input  logic [VOL_W-1:0]   initial_volume,
  input  logic               envelope_increasing,
  input  logic [2:0]         num_envelope_sweeps,
  input  logic [3:0]         shift_clock_freq,
  input  logic               counter_width,
  input  logic [2:0]         freq_dividing_ratio,
  input  logic               start,
  input  logic               single,
  output logic [VOL_W-1:0]   level,
  output logic               enable
`ifdef GB_NOISE_LFSR_OBS_EN
  ,
  output logic [LFSR_W-1:0]  lfsr_state,
  output logic               lfsr_shift
`endif
);

  // The length counter is one bit wider than `length` so that a load of
  // length=0 can hold the full 2^LEN_W count.
  localparam int LEN_CW = LEN_W + 1;

  localparam logic [LEN_CW-1:0]  LEN_FULL  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_CW-1:0]  LEN_ONE   = LEN_CW'(1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [VOL_W-1:0]   VOL_ONE   = VOL_W'(1);
  localparam logic [VOL_W-1:0]   VOL_MAX   = {VOL_W{1'b1}};
  localparam logic [2:0]         ENV_ONE   = 3'd1;

  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LEN_CW-1:0]  len_q, len_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [2:0]         env_q, env_d;
  logic               enable_q, enable_d;

  logic               dac_on;
  logic               rate_frozen;
  logic               shift_now;
  logic [6:0]         divisor;
  logic [TIMER_W-1:0] period;
  logic               fb;
  logic [LFSR_W-1:0]  lfsr_shifted;

  // DAC is powered whenever the envelope can produce a non-zero volume.
  assign dac_on      = (initial_volume != '0) | envelope_increasing;
  // Shift amounts 14 and 15 stop the timer entirely.
  assign rate_frozen = (shift_clock_freq >= 4'd14);

  // Timer period: D(r) << s, with D(0)=8 and D(r)=16*r otherwise.
  always_comb begin
    divisor = (freq_dividing_ratio == 3'd0) ? 7'd8 : {freq_dividing_ratio, 4'b0000};
    period  = {{(TIMER_W-7){1'b0}}, divisor} << shift_clock_freq;
  end

  // Next LFSR value if a shift happens; short mode also drops feedback into SHORT_TAP.
  always_comb begin
    fb           = lfsr_q[0] ^ lfsr_q[1];
    lfsr_shifted = {fb, lfsr_q[LFSR_W-1:1]};
    if (counter_width) begin
      lfsr_shifted[SHORT_TAP] = fb;
    end
  end

  // A shift happens when the running timer expires; a trigger pre-empts it.
  assign shift_now = ~start & enable_q & ~rate_frozen & (timer_q <= TIMER_ONE);

  // Channel next-state: trigger reload has priority over timer, length and envelope.
  always_comb begin
    lfsr_d   = lfsr_q;
    timer_d  = timer_q;
    len_d    = len_q;
    vol_d    = vol_q;
    env_d    = env_q;
    enable_d = enable_q;

    if (start) begin
      lfsr_d   = {LFSR_W{1'b1}};
      timer_d  = period;
      len_d    = LEN_FULL - {1'b0, length};
      vol_d    = initial_volume;
      env_d    = num_envelope_sweeps;
      enable_d = dac_on;
    end else begin
      // Frequency timer runs only while the channel is active and not frozen.
      if (enable_q && !rate_frozen) begin
        if (timer_q <= TIMER_ONE) begin
          lfsr_d  = lfsr_shifted;
          timer_d = period;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      // Length counter: expiring on this tick silences the channel on the same edge.
      if (clk_length_ctr && single && (len_q != '0)) begin
        len_d = len_q - LEN_ONE;
        if (len_q == LEN_ONE) begin
          enable_d = 1'b0;
        end
      end

      // Envelope: a zero sweep count freezes the volume; volume saturates at both ends.
      if (clk_vol_env && (num_envelope_sweeps != 3'd0)) begin
        if (env_q <= ENV_ONE) begin
          env_d = num_envelope_sweeps;
          if (envelope_increasing) begin
            if (vol_q != VOL_MAX) begin
              vol_d = vol_q + VOL_ONE;
            end
          end else begin
            if (vol_q != '0) begin
              vol_d = vol_q - VOL_ONE;
            end
          end
        end else begin
          env_d = env_q - ENV_ONE;
        end
      end

      // An unpowered DAC drops the channel on the next edge.
      if (!dac_on) begin
        enable_d = 1'b0;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q   <= {LFSR_W{1'b1}};
      timer_q  <= '0;
      len_q    <= '0;
      vol_q    <= '0;
      env_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      len_q    <= len_d;
      vol_q    <= vol_d;
      env_q    <= env_d;
      enable_q <= enable_d;
    end
  end

  // Output bit is the inverted LFSR LSB; no extra latency from the registers.
  assign level  = (enable_q & ~lfsr_q[0]) ? vol_q : '0;
  assign enable = enable_q;

`ifdef GB_NOISE_LFSR_OBS_EN
  logic lfsr_shift_q, lfsr_shift_d;

  assign lfsr_shift_d = shift_now;

  // Pulse aligned with the LFSR value produced by the shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_shift_q <= 1'b0;
    end else begin
      lfsr_shift_q <= lfsr_shift_d;
    end
  end

  assign lfsr_state = lfsr_q;
  assign lfsr_shift = lfsr_shift_q;
`else
  logic unused_shift;
  assign unused_shift = shift_now;
`endif

endmodule

// File: tb/tb_gb_noise_channel_gen.sv
// Bench for gb_noise_channel_gen: directed scenarios followed by randomized play,
// all compared against a behavioural channel model kept in the bench.
module tb_gb_noise_channel_gen;

  localparam int LFSR_W    = 15;
  localparam int SHORT_TAP = 6;
  localparam int LEN_W     = 6;
  localparam int VOL_W     = 4;
  localparam int TIMER_W   = 22;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset_n;
  logic             clk_length_ctr;
  logic             clk_vol_env;
  logic [LEN_W-1:0] length;
  logic [VOL_W-1:0] initial_volume;
  logic             envelope_increasing;
  logic [2:0]       num_envelope_sweeps;
  logic [3:0]       shift_clock_freq;
  logic             counter_width;
  logic [2:0]       freq_dividing_ratio;
  logic             start;
  logic             single;
  logic [VOL_W-1:0] level;
  logic             enable;

  always #5 clk = ~clk;

  gb_noise_channel_gen #(
    .LFSR_W(LFSR_W), .SHORT_TAP(SHORT_TAP), .LEN_W(LEN_W),
    .VOL_W(VOL_W), .TIMER_W(TIMER_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .clk_length_ctr(clk_length_ctr), .clk_vol_env(clk_vol_env),
    .length(length), .initial_volume(initial_volume),
    .envelope_increasing(envelope_increasing),
    .num_envelope_sweeps(num_envelope_sweeps),
    .shift_clock_freq(shift_clock_freq), .counter_width(counter_width),
    .freq_dividing_ratio(freq_dividing_ratio), .start(start), .single(single),
    .level(level), .enable(enable)
  );

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timer is modelled as the absolute edge number of the next LFSR shift.
  int m_lfsr, m_next, m_len, m_vol, m_env, cyc;
  bit m_en;

  function automatic int period_of(input int r, input int s);
    return ((r == 0) ? 8 : 16 * r) << s;
  endfunction

  task automatic model_reset();
    m_lfsr = (1 << LFSR_W) - 1;
    m_next = 0;
    m_len  = 0;
    m_vol  = 0;
    m_env  = 0;
    m_en   = 1'b0;
  endtask

  // Applies the inputs currently driven to the model, as one clock edge.
  task automatic model_edge();
    bit dac;
    bit en_next;
    int x;
    cyc++;
    dac = (initial_volume != 0) || envelope_increasing;
    if (start) begin
      m_lfsr = (1 << LFSR_W) - 1;
      m_next = cyc + period_of(freq_dividing_ratio, shift_clock_freq);
      m_len  = (1 << LEN_W) - int'(length);
      m_vol  = int'(initial_volume);
      m_env  = int'(num_envelope_sweeps);
      m_en   = dac;
    end else begin
      en_next = m_en;
      if (m_en && shift_clock_freq < 14 && cyc == m_next) begin
        x      = (m_lfsr ^ (m_lfsr >> 1)) & 1;
        m_lfsr = (m_lfsr >> 1) | (x << (LFSR_W - 1));
        if (counter_width) m_lfsr = (m_lfsr & ~(1 << SHORT_TAP)) | (x << SHORT_TAP);
        m_next = cyc + period_of(freq_dividing_ratio, shift_clock_freq);
      end
      if (clk_length_ctr && single && m_len != 0) begin
        m_len--;
        if (m_len == 0) en_next = 1'b0;
      end
      if (clk_vol_env && num_envelope_sweeps != 0) begin
        if (m_env <= 1) begin
          m_env = int'(num_envelope_sweeps);
          if (envelope_increasing) begin
            if (m_vol < (1 << VOL_W) - 1) m_vol++;
          end else begin
            if (m_vol > 0) m_vol--;
          end
        end else begin
          m_env--;
        end
      end
      if (!dac) en_next = 1'b0;
      m_en = en_next;
    end
  endtask

  function automatic int exp_level();
    return (m_en && (m_lfsr & 1) == 0) ? m_vol : 0;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock: model advances with the driven inputs, DUT sampled on the falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("level", level, exp_level());
    check("enable", enable, m_en);
  endtask

  task automatic setup(input int r, input int s, input int vol, input bit inc,
                       input int sweeps, input int len, input bit sgl, input bit cw);
    freq_dividing_ratio = r[2:0];
    shift_clock_freq    = s[3:0];
    initial_volume      = vol[VOL_W-1:0];
    envelope_increasing = inc;
    num_envelope_sweeps = sweeps[2:0];
    length              = len[LEN_W-1:0];
    single              = sgl;
    counter_width       = cw;
  endtask

  task automatic trigger();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic len_tick();
    clk_length_ctr = 1'b1;
    tick();
    clk_length_ctr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_one;
    int t0;
    int n;
    bit saw_level;

    reset_n = 1'b0;
    clk_length_ctr = 1'b0;
    clk_vol_env    = 1'b0;
    start          = 1'b0;
    setup(0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    cyc = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_level", level, 0);
    check("reset_enable", enable, 0);
    reset_n = 1'b1;

    // Long mode: level rises at the 15th shift, 120 cycles after trigger.
    setup(0, 0, 1, 1'b0, 0, 0, 1'b0, 1'b0);
    trigger();
    t0 = cyc;
    first_one = -1;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (level != 0 && first_one < 0) first_one = cyc - t0;
    end
    check("long_first_one", first_one, 120);
    check("long_level_playing", level, 1);

    // Asynchronous reset mid-play clears outputs without a clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_enable", enable, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Short mode: level rises at the 7th shift, 56 cycles after trigger.
    setup(0, 0, 1, 1'b0, 0, 0, 1'b0, 1'b1);
    trigger();
    t0 = cyc;
    first_one = -1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (level != 0 && first_one < 0) first_one = cyc - t0;
    end
    check("short_first_one", first_one, 56);

    // Length counter: 64-40 = 24 ticks to expire.
    setup(0, 0, 1, 1'b0, 0, 40, 1'b1, 1'b0);
    trigger();
    for (int k = 1; k <= 24; k++) begin
      len_tick();
      tick();
      if (k == 23) check("len_tick23_enable", enable, 1);
      if (k == 24) check("len_tick24_enable", enable, 0);
    end
    repeat (140) tick();
    check("len_expired_level", level, 0);
    setup(0, 0, 1, 1'b0, 0, 40, 1'b0, 1'b0);
    trigger();
    repeat (30) begin
      len_tick();
      tick();
    end
    check("len_nosingle_enable", enable, 1);

    // Envelope up from 1, saturating at 15; observed while the LFSR output is high.
    setup(0, 0, 1, 1'b1, 1, 0, 1'b0, 1'b0);
    trigger();
    repeat (120) tick();
    for (int k = 1; k <= 20; k++) begin
      clk_vol_env = 1'b1;
      tick();
      check("env_up_level", level, (1 + k > 15) ? 15 : 1 + k);
    end
    clk_vol_env = 1'b0;

    // Envelope down from 3, holding at 0 with the channel still enabled.
    setup(0, 0, 3, 1'b0, 1, 0, 1'b0, 1'b0);
    trigger();
    repeat (120) tick();
    for (int k = 1; k <= 5; k++) begin
      clk_vol_env = 1'b1;
      tick();
      check("env_down_level", level, (3 - k < 0) ? 0 : 3 - k);
    end
    clk_vol_env = 1'b0;
    check("env_down_enable", enable, 1);

    // DAC off at trigger, and DAC turned off mid-play.
    setup(0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    trigger();
    check("dac_off_trigger_enable", enable, 0);
    setup(0, 0, 5, 1'b0, 0, 0, 1'b0, 1'b0);
    trigger();
    repeat (4) tick();
    initial_volume = '0;
    tick();
    check("dac_off_midplay_enable", enable, 0);

    // Frozen rate: LFSR never shifts, so level stays 0 while enabled.
    setup(0, 14, 8, 1'b0, 0, 0, 1'b0, 1'b0);
    trigger();
    saw_level = 1'b0;
    repeat (300) begin
      tick();
      if (level != 0) saw_level = 1'b1;
    end
    check("frozen_level_static", saw_level, 0);
    check("frozen_enable", enable, 1);

    // Start coincident with a length tick: start wins and reloads the counter.
    setup(0, 0, 4, 1'b0, 0, 63, 1'b1, 1'b0);
    trigger();
    len_tick();
    check("sim_len_expire", enable, 0);
    length = 6'd62;
    start = 1'b1;
    clk_length_ctr = 1'b1;
    tick();
    start = 1'b0;
    clk_length_ctr = 1'b0;
    check("sim_start_wins", enable, 1);
    len_tick();
    check("sim_reload_tick1", enable, 1);
    len_tick();
    check("sim_reload_tick2", enable, 0);

    // Randomized play against the model.
    for (int seg = 0; seg < 40; seg++) begin
      setup($urandom_range(0, 7),
            ($urandom_range(0, 9) == 0) ? 14 + $urandom_range(0, 1) : $urandom_range(0, 2),
            $urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
            $urandom_range(0, 63), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      trigger();
      n = $urandom_range(60, 300);
      for (int i = 0; i < n; i++) begin
        clk_length_ctr = ($urandom_range(0, 15) == 0);
        clk_vol_env    = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) == 0) counter_width = ~counter_width;
        if ($urandom_range(0, 149) == 0) initial_volume = VOL_W'($urandom_range(0, 15));
        if ($urandom_range(0, 199) == 0) begin
          length = LEN_W'($urandom_range(0, 63));
          freq_dividing_ratio = 3'($urandom_range(0, 7));
          start = 1'b1;
        end
        tick();
        start = 1'b0;
      end
      clk_length_ctr = 1'b0;
      clk_vol_env    = 1'b0;
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
